time_count: RTL and testbench
=============================

TIME_COUNT -- requirements
Module: time_count

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sec (legal range 2..4).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz); all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sec  input  1  1 Hz seconds square wave from the divider; one rising edge per second; treated as asynchronous.
REQ-005 SHALL have port run  input  1  1 = count seconds, 0 = hold time.
REQ-006 SHALL have port load  input  1  one-cycle request to preset time.
REQ-007 SHALL have port load_hh  input  5  preset hours, binary.
REQ-008 SHALL have port load_mm  input  6  preset minutes, binary.
REQ-009 SHALL have port load_ss  input  6  preset seconds, binary.
REQ-010 SHALL have port hh_bcd  output  8  hours, two BCD digits, tens in [7:4].
REQ-011 SHALL have port mm_bcd  output  8  minutes, two BCD digits.
REQ-012 SHALL have port ss_bcd  output  8  seconds, two BCD digits.
REQ-013 SHALL have port tick_out  output  1  one-cycle pulse when seconds advance.
REQ-014 SHALL have port day_wrap  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.
REQ-015 SHALL have port load_err  output  1  one-cycle pulse when a load request is rejected.

Function
REQ-016 sec SHALL pass through a SYNC_STAGES-deep flop chain, then a rising-edge detector (last sync stage high, previous-sample flop low) forming internal tick.
REQ-017 With SYNC_STAGES=2, the first clk edge sampling sec high is edge 1; counters, BCD outputs and tick_out SHALL update at edge 3.
REQ-018 The edge detector SHALL track sec regardless of run; with run=0, ticks are discarded and no backlog is counted when run returns to 1.
REQ-019 Per accepted tick: ss increments; ss 59 -> 0 with mm increment; mm 59 -> 0 with hh increment; hh 23 -> 0.
REQ-020 tick_out SHALL be high for exactly the one cycle following the edge at which an accepted tick updates the counters.
REQ-021 day_wrap SHALL assert in the same cycle as tick_out when the time moves from 23:59:59 to 00:00:00; never otherwise.
REQ-022 load is valid when load_hh <= 23, load_mm <= 59 and load_ss <= 59; a valid load SHALL set the counters at the next clk edge.
REQ-023 An invalid load SHALL leave the counters unchanged and pulse load_err for one cycle; tick_out, day_wrap stay low.
REQ-024 load (valid or invalid) and tick in the same cycle: load takes priority, that tick is discarded, no tick_out or day_wrap.
REQ-025 Load SHALL be accepted regardless of run.
REQ-026 BCD outputs SHALL be registered and change only at the edge where the binary counters change; no cycle where binary and BCD disagree is visible.
REQ-027 Counter registers SHALL never hold out-of-range values (hh > 23, mm or ss > 59).
REQ-028 load held high for N cycles SHALL be treated as N independent requests.

Reset
REQ-029 rst_n low SHALL immediately clear counters to 00:00:00, hh_bcd/mm_bcd/ss_bcd = 8'h00, tick_out/day_wrap/load_err = 0, all sync and edge flops = 0.
REQ-030 Reset mid-operation, including while sec is high, SHALL abort any in-flight tick; if sec is high at release, exactly one tick SHALL follow (edge seen against reset value 0).
REQ-031 Outputs SHALL hold reset values until the first accepted tick or valid load after release.

Verification
REQ-032 Reset, run=1, three sec rising edges -> ss_bcd = 8'h03, mm_bcd = hh_bcd = 8'h00, three tick_out pulses, each at edge 3 after sec first sampled high.
REQ-033 Load 23:59:58, two sec edges -> 23:59:59 then 00:00:00; day_wrap pulses once, coincident with the second tick_out.
REQ-034 Load hh=24, mm=10, ss=0 -> load_err one-cycle pulse, time unchanged; load 12:60:00 -> same result.
REQ-035 Assert load 05:30:00 in the exact cycle internal tick is high -> time 05:30:00, no tick_out, next sec edge gives 05:30:01.
REQ-036 run=0 across five sec edges, then run=1 -> time unchanged during hold, resumes +1 per subsequent edge with no burst.
REQ-037 Assert rst_n low while sec high after 00:00:59 -> immediate 00:00:00, all pulses low; release with sec high -> one tick, ss_bcd = 8'h01.

Source files
------------

// File: rtl/time_count.sv
// Time-of-day counter: synchronises a 1 Hz square wave, counts hh:mm:ss in binary,
// accepts range-checked presets and presents registered BCD copies of the time.
module time_count #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sec,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic       tick_out,
  output logic       day_wrap,
  output logic       load_err
);

  localparam int unsigned HW = 5;
  localparam int unsigned MW = 6;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [HW-1:0]          hh_q, hh_d;
  logic [MW-1:0]          mm_q, mm_d;
  logic [MW-1:0]          ss_q, ss_d;
  logic [7:0]             hh_bcd_q, hh_bcd_d;
  logic [7:0]             mm_bcd_q, mm_bcd_d;
  logic [7:0]             ss_bcd_q, ss_bcd_d;
  logic                   tick_out_q, tick_out_d;
  logic                   day_wrap_q, day_wrap_d;
  logic                   load_err_q, load_err_d;
  logic                   tick_c;
  logic                   load_ok_c;

  // Binary (0..59) to two packed BCD digits.
  function automatic logic [7:0] to_bcd(input logic [MW-1:0] v);
    logic [MW-1:0] tens;
    tens = v / MW'(10);
    return {4'(tens), 4'(v - tens * MW'(10))};
  endfunction

  assign tick_c    = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign load_ok_c = (load_hh <= HW'(23)) && (load_mm <= MW'(59)) && (load_ss <= MW'(59));

  // Next-state: load beats tick; BCD is derived from the next binary value so both move together.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], sec};
    prev_d     = sync_q[SYNC_STAGES-1];
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    tick_out_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;

    if (load) begin
      if (load_ok_c) begin
        hh_d = load_hh;
        mm_d = load_mm;
        ss_d = load_ss;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick_c && run) begin
      tick_out_d = 1'b1;
      if (ss_q >= MW'(59)) begin
        ss_d = '0;
        if (mm_q >= MW'(59)) begin
          mm_d = '0;
          if (hh_q >= HW'(23)) begin
            hh_d       = '0;
            day_wrap_d = 1'b1;
          end else begin
            hh_d = hh_q + HW'(1);
          end
        end else begin
          mm_d = mm_q + MW'(1);
        end
      end else begin
        ss_d = ss_q + MW'(1);
      end
    end

    hh_bcd_d = to_bcd(MW'(hh_d));
    mm_bcd_d = to_bcd(mm_d);
    ss_bcd_d = to_bcd(ss_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      hh_bcd_q   <= '0;
      mm_bcd_q   <= '0;
      ss_bcd_q   <= '0;
      tick_out_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      hh_bcd_q   <= hh_bcd_d;
      mm_bcd_q   <= mm_bcd_d;
      ss_bcd_q   <= ss_bcd_d;
      tick_out_q <= tick_out_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign hh_bcd   = hh_bcd_q;
  assign mm_bcd   = mm_bcd_q;
  assign ss_bcd   = ss_bcd_q;
  assign tick_out = tick_out_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_time_count.sv
// Scoreboard bench for time_count: a seconds-of-day model predicts every visible event
// (tick, load, rejected load) with its cycle; a negedge monitor pops and compares.
module tb_time_count;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec = 1'b0;
  logic       run = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hh = '0;
  logic [5:0] load_mm = '0;
  logic [5:0] load_ss = '0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic       tick_out, day_wrap, load_err;

  time_count #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sec(sec), .run(run), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .tick_out(tick_out), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    int cyc;
    bit tk;
    bit dw;
    bit le;
    int t;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_t = 0;      // model time in seconds of day
  int  last_t = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int now_t();
    return dec(hh_bcd) * 3600 + dec(mm_bcd) * 60 + dec(ss_bcd);
  endfunction

  // Monitor: any pulse or visible time change is an event that must match the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_t = 0;
    end else begin
      int at;
      at = now_t();
      if (tick_out || day_wrap || load_err || at != last_t) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event cyc=%0d tick=%0b wrap=%0b err=%0b t=%0d", cyc, tick_out, day_wrap, load_err, at);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.tk != tick_out || e.dw != day_wrap || e.le != load_err || e.t != at) begin
            n_bad++;
            $display("FAIL event got cyc=%0d tick=%0b wrap=%0b err=%0b t=%0d expected cyc=%0d tick=%0b wrap=%0b err=%0b t=%0d",
                     cyc, tick_out, day_wrap, load_err, at, e.cyc, e.tk, e.dw, e.le, e.t);
          end
        end
        last_t = at;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input bit tk, input bit dw, input bit le, input int t, input int c);
    ev_t e;
    e.cyc = c; e.tk = tk; e.dw = dw; e.le = le; e.t = t;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hh"}, int'(hh_bcd), 0);
    chk({tag, "_mm"}, int'(mm_bcd), 0);
    chk({tag, "_ss"}, int'(ss_bcd), 0);
    chk({tag, "_pulses"}, int'({tick_out, day_wrap, load_err}), 0);
  endtask

  // One sec pulse; accepted ticks are visible three edges after sec first sampled high.
  task automatic do_tick();
    int c0;
    c0 = cyc;
    sec = 1'b1;
    if (run) begin
      m_t = (m_t + 1) % 86400;
      push(1'b1, m_t == 0, 1'b0, m_t, c0 + 3);
    end
    step(4);
    sec = 1'b0;
    step(3);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    int c0;
    c0 = cyc;
    load_hh = 5'(h); load_mm = 6'(m); load_ss = 6'(s);
    load = 1'b1;
    if (h <= 23 && m <= 59 && s <= 59) begin
      if (h * 3600 + m * 60 + s != m_t) push(1'b0, 1'b0, 1'b0, h * 3600 + m * 60 + s, c0 + 1);
      m_t = h * 3600 + m * 60 + s;
    end else begin
      push(1'b0, 1'b0, 1'b1, m_t, c0 + 1);
    end
    step(1);
    load = 1'b0;
    step(2);
  endtask

  initial begin
    int c0;
    step(3);
    chk_zero("reset");
    rst_n = 1'b1;
    step(4);
    chk_zero("post_release");

    // Three counted seconds.
    run = 1'b1;
    repeat (3) do_tick();
    chk("ss_after_three", int'(ss_bcd), 8'h03);

    // Midnight rollover.
    do_load(23, 59, 58);
    repeat (2) do_tick();

    // Rejected presets.
    do_load(24, 10, 0);
    do_load(12, 60, 0);

    // Load coincident with the internal tick wins and swallows it.
    c0 = cyc;
    sec = 1'b1;
    step(2);
    load_hh = 5'd5; load_mm = 6'd30; load_ss = 6'd0;
    load = 1'b1;
    m_t = 5 * 3600 + 30 * 60;
    push(1'b0, 1'b0, 1'b0, m_t, c0 + 3);
    step(1);
    load = 1'b0;
    step(2);
    sec = 1'b0;
    step(3);
    do_tick();

    // Hold, then resume with no backlog.
    run = 1'b0;
    repeat (5) do_tick();
    run = 1'b1;
    repeat (2) do_tick();

    // Randomised mix.
    for (int i = 0; i < 30; i++) begin
      int r;
      r = int'($urandom_range(0, 4));
      case (r)
        0, 1: begin run = 1'b1; do_tick(); end
        2:    begin run = 1'b0; do_tick(); end
        3:    do_load(int'($urandom_range(0, 25)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        default: begin
          do_load(int'($urandom_range(22, 23)), 59, int'($urandom_range(57, 59)));
          run = 1'b1;
          repeat (3) do_tick();
        end
      endcase
    end

    // Reset while a tick is in flight, release with sec still high.
    run = 1'b1;
    do_load(0, 0, 58);
    do_tick();
    sec = 1'b1;
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    m_t = 0;
    step(3);
    m_t = 1;
    push(1'b1, 1'b0, 1'b0, 1, cyc + 3);
    rst_n = 1'b1;
    step(5);
    sec = 1'b0;
    step(3);
    chk("ss_after_reset_tick", int'(ss_bcd), 8'h01);

    step(5);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
